// File: rtl/seven_seg_display_driver.sv
// Registered multi-digit seven-segment driver (active-low segments) with hex or
// decimal display, leading-zero blanking, overflow dashes and blinking.
module seven_seg_display_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      mode_dec,
  input  logic                      blank_lz,
  input  logic                      blink_en,
  output logic                      busy,
  output logic                      overflow,
  output logic [7*NUM_DIGITS-1:0]   hex_out
);

  localparam int W          = 4 * NUM_DIGITS;
  localparam int BCD_DIGITS = NUM_DIGITS + NUM_DIGITS / 4 + 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int ITER_W     = $clog2(W);
  localparam int CNT_W      = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t              r_state, w_state_next;
  logic [W-1:0]        r_bin;
  logic [BCD_W-1:0]    r_bcd;
  logic [ITER_W-1:0]   r_iter;
  logic [W-1:0]        r_disp;
  logic                r_blank;
  logic                r_overflow;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_phase;

  logic [BCD_W-1:0]    w_bcd_adj;
  logic [BCD_W-1:0]    w_bcd_shift;
  logic [W-1:0]        w_bin_shift;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [7*NUM_DIGITS-1:0] w_hex_next;

  function automatic logic [6:0] f_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign busy     = (r_state == S_CONV);
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (load && mode_dec) w_state_next = S_CONV;
      S_CONV:  if (r_iter == '0)     w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Double-dabble step: add 3 to digits >= 5, then shift {bcd,bin} left.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  assign w_bcd_shift = {w_bcd_adj[BCD_W-2:0], r_bin[W-1]};
  assign w_bin_shift = {r_bin[W-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_iter     <= '0;
      r_disp     <= '0;
      r_blank    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load && mode_dec) begin
            r_bin  <= value;
            r_bcd  <= '0;
            r_iter <= ITER_W'(W - 1);
          end else if (load) begin
            r_disp     <= value;
            r_blank    <= 1'b0;
            r_overflow <= 1'b0;
          end
        end
        S_CONV: begin
          r_bcd  <= w_bcd_shift;
          r_bin  <= w_bin_shift;
          r_iter <= r_iter - ITER_W'(1);
          if (r_iter == '0) begin
            r_disp     <= w_bcd_shift[W-1:0];
            r_overflow <= |w_bcd_shift[BCD_W-1:W];
            r_blank    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    logic v_upper_zero;
    v_upper_zero = 1'b1;
    w_lz         = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      v_upper_zero = v_upper_zero && (r_disp[4*k +: 4] == 4'd0);
      w_lz[k]      = v_upper_zero && (k != 0);
    end
  end

  always_comb begin
    w_hex_next = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_blank || (blink_en && r_phase)) w_hex_next[7*k +: 7] = SEG_OFF;
      else if (r_overflow)                  w_hex_next[7*k +: 7] = SEG_DASH;
      else if (blank_lz && w_lz[k])         w_hex_next[7*k +: 7] = SEG_OFF;
      else                                  w_hex_next[7*k +: 7] = f_glyph(r_disp[4*k +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) hex_out <= '1;
    else         hex_out <= w_hex_next;
  end

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Bench for seven_seg_display_driver: vector table, corner-case sequences and
// random stimulus checked every cycle against an arithmetic reference model.
module tb_seven_seg_display_driver;
  localparam int ND = 4;
  localparam int BD = 4;

  localparam logic [6:0] OFF  = 7'h7F;
  localparam logic [6:0] DASH = 7'h3F;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        resetn, load, mode_dec, blank_lz, blink_en;
  logic [15:0] value;
  logic        busy, overflow;
  logic [27:0] hex_out;

  always #5 clk = ~clk;

  seven_seg_display_driver #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk(clk), .resetn(resetn), .load(load), .value(value), .mode_dec(mode_dec),
    .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy), .overflow(overflow), .hex_out(hex_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: display content as decimal/hex digits, busy as a countdown,
  // blink phase from the number of edges since reset.
  int          m_dig [4];
  bit          m_blank, m_ovf, m_valid;
  int          m_busy, m_conv, m_edges;
  logic [27:0] m_hex;
  bit          chk_en = 1'b0;

  function automatic logic [27:0] model_hex(input bit phase);
    logic [27:0] r;
    logic [6:0]  g;
    bit          upper_zero;
    r = '1;
    upper_zero = 1'b1;
    if (m_blank || (blink_en && phase)) return r;
    for (int k = 3; k >= 0; k--) begin
      upper_zero = upper_zero && (m_dig[k] == 0);
      if (m_ovf)                               g = DASH;
      else if (blank_lz && upper_zero && k != 0) g = OFF;
      else                                     g = GLYPH[m_dig[k]];
      r[7*k +: 7] = g;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_hex = '1; m_blank = 1'b1; m_ovf = 1'b0; m_busy = 0; m_edges = 0; m_valid = 1'b1;
      for (int k = 0; k < 4; k++) m_dig[k] = 0;
    end else begin
      m_hex = model_hex(((m_edges / BD) % 2) == 1);
      m_edges++;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_ovf   = (m_conv > 9999);
          m_blank = 1'b0;
          for (int k = 0; k < 4; k++) m_dig[k] = (m_conv / (10 ** k)) % 10;
        end
      end else if (load) begin
        if (mode_dec) begin
          m_busy = 16;
          m_conv = int'(value);
        end else begin
          m_ovf   = 1'b0;
          m_blank = 1'b0;
          for (int k = 0; k < 4; k++) m_dig[k] = (int'(value) >> (4 * k)) & 15;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && m_valid) begin
      check("model_hex", hex_out, m_hex);
      check("model_busy", {27'd0, busy}, {27'd0, m_busy > 0});
      check("model_ovf", {27'd0, overflow}, {27'd0, m_ovf});
    end
  end

  typedef struct {
    logic [15:0] value;
    logic        mode_dec;
    logic        blank_lz;
    logic [27:0] exp_hex;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic run_load(input logic [15:0] v, input logic md, input logic blz);
    value = v; mode_dec = md; blank_lz = blz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("busy_settle", {27'd0, busy}, 28'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles, off_cnt, lit_cnt;
    bit extra_done;

    vecs[0]  = '{16'h00A3, 1'b0, 1'b1, {OFF, OFF, GLYPH[10], GLYPH[3]}, 1'b0};
    vecs[1]  = '{16'h00A3, 1'b0, 1'b0, {GLYPH[0], GLYPH[0], GLYPH[10], GLYPH[3]}, 1'b0};
    vecs[2]  = '{16'd1234, 1'b1, 1'b0, {GLYPH[1], GLYPH[2], GLYPH[3], GLYPH[4]}, 1'b0};
    vecs[3]  = '{16'hFFFF, 1'b1, 1'b0, {DASH, DASH, DASH, DASH}, 1'b1};
    vecs[4]  = '{16'hFFFF, 1'b0, 1'b0, {GLYPH[15], GLYPH[15], GLYPH[15], GLYPH[15]}, 1'b0};
    vecs[5]  = '{16'd0, 1'b1, 1'b1, {OFF, OFF, OFF, GLYPH[0]}, 1'b0};
    vecs[6]  = '{16'd9999, 1'b1, 1'b0, {GLYPH[9], GLYPH[9], GLYPH[9], GLYPH[9]}, 1'b0};
    vecs[7]  = '{16'd10000, 1'b1, 1'b1, {DASH, DASH, DASH, DASH}, 1'b1};
    vecs[8]  = '{16'h0B0C, 1'b0, 1'b1, {OFF, GLYPH[11], GLYPH[0], GLYPH[12]}, 1'b0};
    vecs[9]  = '{16'h8E0D, 1'b0, 1'b1, {GLYPH[8], GLYPH[14], GLYPH[0], GLYPH[13]}, 1'b0};
    vecs[10] = '{16'd305, 1'b1, 1'b1, {OFF, GLYPH[3], GLYPH[0], GLYPH[5]}, 1'b0};

    resetn = 1'b0; load = 1'b0; value = '0; mode_dec = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_hex", hex_out, 28'hFFFFFFF);
    check("reset_busy", {27'd0, busy}, 28'd0);
    check("reset_ovf", {27'd0, overflow}, 28'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_load(vecs[i].value, vecs[i].mode_dec, vecs[i].blank_lz);
      check("vec_hex", hex_out, vecs[i].exp_hex);
      check("vec_ovf", {27'd0, overflow}, {27'd0, vecs[i].exp_ovf});
    end

    // Decimal conversion with a dropped load in the middle of it.
    blank_lz = 1'b0; value = 16'd1234; mode_dec = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    busy_cycles = 0; extra_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cycles++;
      if (busy_cycles == 5 && !extra_done) begin
        value = 16'h0042; mode_dec = 1'b0; load = 1'b1; extra_done = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_len", 28'(busy_cycles), 28'd16);
    check("dec_1234", hex_out, {GLYPH[1], GLYPH[2], GLYPH[3], GLYPH[4]});

    // Blink on a stable display: half the samples dark, then steady again.
    blink_en = 1'b1;
    @(negedge clk);
    off_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (hex_out == 28'hFFFFFFF) off_cnt++;
      @(negedge clk);
    end
    check("blink_off_cnt", 28'(off_cnt), 28'd8);
    blink_en = 1'b0;
    @(negedge clk);
    lit_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (hex_out == {GLYPH[1], GLYPH[2], GLYPH[3], GLYPH[4]}) lit_cnt++;
      @(negedge clk);
    end
    check("steady_cnt", 28'(lit_cnt), 28'd8);

    // Reset in the middle of a conversion.
    value = 16'd4321; mode_dec = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_hex", hex_out, 28'hFFFFFFF);
    check("abort_busy", {27'd0, busy}, 28'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("abort_dark", hex_out, 28'hFFFFFFF);
    run_load(16'd0, 1'b1, 1'b1);
    check("zero_lz", hex_out, {OFF, OFF, OFF, GLYPH[0]});

    for (int i = 0; i < 600; i++) begin
      resetn   = ($urandom_range(0, 150) != 0);
      load     = ($urandom_range(0, 3) == 0);
      mode_dec = 1'($urandom_range(0, 1));
      value    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
      blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) blink_en = ~blink_en;
      @(negedge clk);
    end
    resetn = 1'b1; load = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
